// File: rtl/ecg_measurement_sequencer.sv
//----------------------------------------------------------------------------
// ecg_measurement_sequencer: session control between ADC, HR converter, display
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module ecg_measurement_sequencer #(
  parameter int SAMPLE_DIV     = 1000,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] cfg_min_thr,
  input  logic [7:0] cfg_max_thr,
  input  logic [7:0] cfg_max_checks,
  input  logic [7:0] cfg_max_rate,
  output logic       adc_req,
  input  logic       adc_ack,
  input  logic [9:0] adc_data,
  output logic       conv_measuring,
  output logic [9:0] conv_adc,
  output logic [7:0] conv_min_thr,
  output logic [7:0] conv_max_thr,
  output logic [7:0] conv_max_checks,
  output logic [7:0] conv_max_rate,
  input  logic       conv_done,
  input  logic [7:0] conv_count,
  input  logic [7:0] conv_avg,
  input  logic [7:0] conv_ok,
  input  logic [7:0] conv_min_viol,
  input  logic [7:0] conv_max_viol,
  output logic       res_valid,
  input  logic       res_ready,
  output logic [7:0] res_count,
  output logic [7:0] res_avg,
  output logic [7:0] res_ok,
  output logic [7:0] res_min_viol,
  output logic [7:0] res_max_viol,
  output logic [1:0] res_status,
  output logic       busy
);

  localparam int SCNT_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [SCNT_W-1:0] SCNT_RAISE   = SCNT_W'(SAMPLE_DIV - 2);
  localparam logic [15:0]       TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ST_OK      = 2'b00;
  localparam logic [1:0] ST_TIMEOUT = 2'b01;
  localparam logic [1:0] ST_ABORTED = 2'b10;
  localparam logic [1:0] ST_CFGERR  = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CHECK   = 3'd1,
    S_MEASURE = 3'd2,
    S_LATCH   = 3'd3,
    S_REPORT  = 3'd4
  } state_t;

  state_t            state;
  logic              first_seen;
  logic [SCNT_W-1:0] sample_cnt;
  logic [15:0]       timeout_cnt;
  logic              cfg_error;

  // Validation runs on the latched copy so the inputs may change after start.
  assign cfg_error = (conv_min_thr > conv_max_thr) || (conv_max_checks == 8'd0) ||
                     (conv_max_rate == 8'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= S_IDLE;
      first_seen      <= 1'b0;
      sample_cnt      <= '0;
      timeout_cnt     <= 16'd0;
      adc_req         <= 1'b0;
      conv_measuring  <= 1'b0;
      conv_adc        <= 10'd0;
      conv_min_thr    <= 8'd0;
      conv_max_thr    <= 8'd0;
      conv_max_checks <= 8'd0;
      conv_max_rate   <= 8'd0;
      res_valid       <= 1'b0;
      res_count       <= 8'd0;
      res_avg         <= 8'd0;
      res_ok          <= 8'd0;
      res_min_viol    <= 8'd0;
      res_max_viol    <= 8'd0;
      res_status      <= 2'b00;
      busy            <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            conv_min_thr    <= cfg_min_thr;
            conv_max_thr    <= cfg_max_thr;
            conv_max_checks <= cfg_max_checks;
            conv_max_rate   <= cfg_max_rate;
            busy            <= 1'b1;
            state           <= S_CHECK;
          end
        end

        S_CHECK: begin
          if (cfg_error) begin
            {res_count, res_avg, res_ok, res_min_viol, res_max_viol} <= 40'd0;
            res_status <= ST_CFGERR;
            res_valid  <= 1'b1;
            state      <= S_REPORT;
          end else begin
            conv_measuring <= 1'b1;
            adc_req        <= 1'b1;
            conv_adc       <= 10'd0;
            first_seen     <= 1'b0;
            sample_cnt     <= '0;
            timeout_cnt    <= 16'd0;
            state          <= S_MEASURE;
          end
        end

        S_MEASURE: begin
          if (timeout_cnt != 16'hFFFF) begin
            timeout_cnt <= timeout_cnt + 16'd1;
          end
          if (adc_req) begin
            if (adc_ack) begin
              conv_adc   <= adc_data;
              first_seen <= 1'b1;
              sample_cnt <= '0;
              adc_req    <= 1'b0;
            end
          end else begin
            // Request is registered, so it is raised one count early to land
            // exactly SAMPLE_DIV cycles after the capture.
            sample_cnt <= sample_cnt + SCNT_W'(1);
            if (sample_cnt == SCNT_RAISE) begin
              adc_req <= 1'b1;
            end
          end

          if (abort) begin
            {res_count, res_avg, res_ok, res_min_viol, res_max_viol} <= 40'd0;
            res_status     <= ST_ABORTED;
            res_valid      <= 1'b1;
            conv_measuring <= 1'b0;
            adc_req        <= 1'b0;
            state          <= S_REPORT;
          end else if (conv_done && first_seen) begin
            adc_req <= 1'b0;
            state   <= S_LATCH;
          end else if (timeout_cnt == TIMEOUT_LAST) begin
            {res_count, res_avg, res_ok, res_min_viol, res_max_viol} <=
              {conv_count, conv_avg, conv_ok, conv_min_viol, conv_max_viol};
            res_status     <= ST_TIMEOUT;
            res_valid      <= 1'b1;
            conv_measuring <= 1'b0;
            adc_req        <= 1'b0;
            state          <= S_REPORT;
          end
        end

        S_LATCH: begin
          if (abort) begin
            {res_count, res_avg, res_ok, res_min_viol, res_max_viol} <= 40'd0;
            res_status <= ST_ABORTED;
          end else begin
            {res_count, res_avg, res_ok, res_min_viol, res_max_viol} <=
              {conv_count, conv_avg, conv_ok, conv_min_viol, conv_max_viol};
            res_status <= ST_OK;
          end
          res_valid      <= 1'b1;
          conv_measuring <= 1'b0;
          state          <= S_REPORT;
        end

        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            busy      <= 1'b0;
            state     <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ecg_measurement_sequencer.sv
//----------------------------------------------------------------------------
// tb_ecg_measurement_sequencer: randomized sessions against a timeline model
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_ecg_measurement_sequencer;

  localparam int SAMPLE_DIV     = 4;
  localparam int TIMEOUT_CYCLES = 20;
  localparam int ACK_NEVER      = 99;

  logic       clk = 1'b0;
  logic       reset, start, abort;
  logic [7:0] cfg_min_thr, cfg_max_thr, cfg_max_checks, cfg_max_rate;
  logic       adc_req, adc_ack;
  logic [9:0] adc_data;
  logic       conv_measuring;
  logic [9:0] conv_adc;
  logic [7:0] conv_min_thr, conv_max_thr, conv_max_checks, conv_max_rate;
  logic       conv_done;
  logic [7:0] conv_count, conv_avg, conv_ok, conv_min_viol, conv_max_viol;
  logic       res_valid, res_ready;
  logic [7:0] res_count, res_avg, res_ok, res_min_viol, res_max_viol;
  logic [1:0] res_status;
  logic       busy;

  int checks   = 0;
  int failures = 0;
  bit fixed_res = 1'b0;

  ecg_measurement_sequencer #(
    .SAMPLE_DIV    (SAMPLE_DIV),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_min_thr(cfg_min_thr), .cfg_max_thr(cfg_max_thr),
    .cfg_max_checks(cfg_max_checks), .cfg_max_rate(cfg_max_rate),
    .adc_req(adc_req), .adc_ack(adc_ack), .adc_data(adc_data),
    .conv_measuring(conv_measuring), .conv_adc(conv_adc),
    .conv_min_thr(conv_min_thr), .conv_max_thr(conv_max_thr),
    .conv_max_checks(conv_max_checks), .conv_max_rate(conv_max_rate),
    .conv_done(conv_done), .conv_count(conv_count), .conv_avg(conv_avg),
    .conv_ok(conv_ok), .conv_min_viol(conv_min_viol), .conv_max_viol(conv_max_viol),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_count(res_count), .res_avg(res_avg), .res_ok(res_ok),
    .res_min_viol(res_min_viol), .res_max_viol(res_max_viol),
    .res_status(res_status), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [39:0] conv_results();
    return {conv_count, conv_avg, conv_ok, conv_min_viol, conv_max_viol};
  endfunction

  function automatic logic [39:0] res_results();
    return {res_count, res_avg, res_ok, res_min_viol, res_max_viol};
  endfunction

  task automatic drive_conv_results();
    if (fixed_res)
      {conv_count, conv_avg, conv_ok, conv_min_viol, conv_max_viol} = {8'd10, 8'd100, 8'd9, 8'd1, 8'd0};
    else
      {conv_count, conv_avg, conv_ok, conv_min_viol, conv_max_viol} = {$urandom, $urandom};
  endtask

  function automatic int pick_delay(input int ack_d);
    return (ack_d < 0) ? int'($urandom_range(0, 3)) : ack_d;
  endfunction

  task automatic check_all_zero(input string tag);
    check_value({tag, ".ctl"}, {adc_req, conv_measuring, res_valid, busy, res_status}, 0);
    check_value({tag, ".adc"}, conv_adc, 0);
    check_value({tag, ".cfg"}, {conv_min_thr, conv_max_thr, conv_max_checks, conv_max_rate}, 0);
    check_value({tag, ".res"}, res_results(), 0);
  endtask

  // Session timeline: request k rises at measure cycle rise, is acked d cycles
  // later, and the next request rises SAMPLE_DIV cycles after that capture.
  task automatic run_session(input logic [7:0] mn, input logic [7:0] mx,
                             input logic [7:0] ck, input logic [7:0] rt,
                             input int ack_d, input int done_pct, input bit abort_with_done,
                             input int abort_pct, input int latch_abort_pct);
    bit          bad, seen, go_latch, exit_found, captured;
    logic [1:0]  exp_status;
    logic [39:0] exp_res;
    logic [9:0]  exp_adc;
    int          rise, d, m, hold;
    bad = (mn > mx) || (ck == 8'd0) || (rt == 8'd0);
    exp_status = 2'b00;
    exp_res = 40'd0;
    {cfg_min_thr, cfg_max_thr, cfg_max_checks, cfg_max_rate} = {mn, mx, ck, rt};
    start = 1'b1;
    abort = 1'b0;
    tick();
    start = 1'b0;
    check_value("check.ctl", {busy, conv_measuring, adc_req, res_valid}, 4'b1000);
    check_value("check.cfg", {conv_min_thr, conv_max_thr, conv_max_checks, conv_max_rate},
                {mn, mx, ck, rt});
    {cfg_min_thr, cfg_max_thr, cfg_max_checks, cfg_max_rate} = $urandom;
    tick();
    if (bad) begin
      exp_status = 2'b11;
      exp_res = 40'd0;
    end else begin
      rise = 0;
      d = pick_delay(ack_d);
      seen = 1'b0;
      exp_adc = 10'd0;
      go_latch = 1'b0;
      exit_found = 1'b0;
      m = 0;
      while (!exit_found) begin
        check_value("meas.req", adc_req, (m >= rise) && (m <= rise + d));
        check_value("meas.gate", {conv_measuring, res_valid, busy}, 3'b101);
        check_value("meas.adc", conv_adc, exp_adc);
        captured = (m == rise + d);
        adc_ack = captured || ((m < rise) && ($urandom_range(0, 2) == 0));
        adc_data = 10'($urandom);
        conv_done = seen ? ($urandom_range(0, 99) < done_pct) : ($urandom_range(0, 1) == 1);
        abort = ($urandom_range(0, 99) < abort_pct) || (abort_with_done && seen && conv_done);
        drive_conv_results();
        if (abort) begin
          exp_status = 2'b10;
          exp_res = 40'd0;
          exit_found = 1'b1;
        end else if (seen && conv_done) begin
          go_latch = 1'b1;
          exit_found = 1'b1;
        end else if (m == TIMEOUT_CYCLES - 1) begin
          exp_status = 2'b01;
          exp_res = conv_results();
          exit_found = 1'b1;
        end
        if (captured) begin
          exp_adc = adc_data;
          seen = 1'b1;
          rise = m + SAMPLE_DIV;
          d = pick_delay(ack_d);
        end
        tick();
        m++;
        if (!exit_found && m > TIMEOUT_CYCLES + 5) begin
          $display("FAIL meas.bound: got %0d cycles expected at most %0d", m, TIMEOUT_CYCLES);
          $fatal(1);
        end
      end
      adc_ack = 1'b0;
      if (go_latch) begin
        check_value("latch.gate", {conv_measuring, res_valid, busy}, 3'b101);
        conv_done = $urandom_range(0, 1) == 1;
        abort = $urandom_range(0, 99) < latch_abort_pct;
        drive_conv_results();
        if (abort) begin
          exp_status = 2'b10;
          exp_res = 40'd0;
        end else begin
          exp_status = 2'b00;
          exp_res = conv_results();
        end
        tick();
      end
    end
    abort = 1'b0;
    conv_done = 1'b0;
    hold = $urandom_range(0, 5);
    for (int k = 0; k <= hold; k++) begin
      check_value("rep.ctl", {res_valid, busy, conv_measuring, adc_req}, 4'b1100);
      check_value("rep.status", res_status, exp_status);
      check_value("rep.res", res_results(), exp_res);
      res_ready = (k == hold);
      start = $urandom_range(0, 1) == 1;
      abort = $urandom_range(0, 1) == 1;
      adc_ack = $urandom_range(0, 1) == 1;
      drive_conv_results();
      tick();
    end
    {res_ready, start, abort, adc_ack} = 4'b0000;
    check_value("idle.ctl", {res_valid, busy, conv_measuring, adc_req}, 4'b0000);
    check_value("idle.res", {res_status, res_results()}, {exp_status, exp_res});
  endtask

  task automatic run_random_session();
    logic [7:0] mn, mx, ck, rt;
    if ($urandom_range(0, 4) == 0) begin
      {mn, mx, ck, rt} = $urandom;
      if ($urandom_range(0, 1) == 1) ck = 8'd0;
    end else begin
      mn = 8'($urandom_range(0, 127));
      mx = 8'($urandom_range(int'(mn), 255));
      ck = 8'($urandom_range(1, 255));
      rt = 8'($urandom_range(1, 255));
    end
    run_session(mn, mx, ck, rt, -1, $urandom_range(0, 30), 1'b0,
                $urandom_range(0, 5), $urandom_range(0, 30));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    {start, abort, adc_ack, conv_done, res_ready} = 5'b00000;
    {cfg_min_thr, cfg_max_thr, cfg_max_checks, cfg_max_rate} = 32'd0;
    adc_data = 10'd0;
    drive_conv_results();
    tick();
    tick();
    reset = 1'b0;
    check_all_zero("reset");

    run_session(8'd120, 8'd60, 8'd10, 8'd200, -1, 20, 1'b0, 0, 0);
    run_session(8'd50, 8'd100, 8'd0, 8'd200, -1, 20, 1'b0, 0, 0);
    run_session(8'd50, 8'd100, 8'd10, 8'd0, -1, 20, 1'b0, 0, 0);
    fixed_res = 1'b1;
    run_session(8'd50, 8'd100, 8'd10, 8'd200, 2, 100, 1'b0, 0, 0);
    fixed_res = 1'b0;
    run_session(8'd50, 8'd100, 8'd10, 8'd200, 2, 10, 1'b0, 0, 0);
    run_session(8'd50, 8'd100, 8'd10, 8'd200, ACK_NEVER, 0, 1'b0, 0, 0);
    run_session(8'd50, 8'd100, 8'd10, 8'd200, -1, 100, 1'b1, 0, 0);
    run_session(8'd50, 8'd100, 8'd10, 8'd200, -1, 100, 1'b0, 0, 100);
    run_session(8'd80, 8'd80, 8'd1, 8'd1, 0, 0, 1'b0, 0, 0);

    // Reset in the first MEASURE cycle, while the first request is outstanding.
    {cfg_min_thr, cfg_max_thr, cfg_max_checks, cfg_max_rate} = {8'd50, 8'd100, 8'd10, 8'd200};
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check_value("rst.req", {adc_req, conv_measuring}, 2'b11);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_all_zero("rst.mid");
    run_session(8'd50, 8'd100, 8'd10, 8'd200, -1, 20, 1'b0, 0, 0);

    for (int s = 0; s < 30; s++) begin
      run_random_session();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ecg_measurement_sequencer.md
Name: ecg_measurement_sequencer

Overview:
Session controller for the ADC-to-heart-rate converter. It validates and latches the user configuration, paces ADC sampling through a request/acknowledge handshake, and drives the converter's measuring gate and ADC input. When the session ends it snapshots the converter results and hands them to the display path through a valid/ready handshake, with a status code. It sits between the front-panel/start logic, the ADC interface and the converter.

Parameters:
SAMPLE_DIV, 1000, clock cycles from one sample capture to the next ADC request (>=2)
TIMEOUT_CYCLES, 65535, maximum MEASURE-state cycles before a timeout (16-bit counter)

Ports:
clk  in  1  clock
reset  in  1  reset, synchronous, active-high
start  in  1  session start pulse; ignored unless IDLE
abort  in  1  abort request; level-sampled each cycle
cfg_min_thr  in  8  minimum heart-rate threshold
cfg_max_thr  in  8  maximum heart-rate threshold
cfg_max_checks  in  8  converter check limit
cfg_max_rate  in  8  full-scale heart rate
adc_req  out  1  ADC sample request
adc_ack  in  1  ADC data valid; meaningful only while adc_req=1
adc_data  in  10  ADC sample
conv_measuring  out  1  converter measuring gate
conv_adc  out  10  held ADC sample to converter
conv_min_thr / conv_max_thr / conv_max_checks / conv_max_rate  out  8 each  latched config to converter
conv_done  in  1  converter done flag
conv_count / conv_avg / conv_ok / conv_min_viol / conv_max_viol  in  8 each  converter results
res_valid  out  1  result available
res_ready  in  1  display accepts result
res_count / res_avg / res_ok / res_min_viol / res_max_viol  out  8 each  captured results
res_status  out  2  00 OK, 01 TIMEOUT, 10 ABORTED, 11 CONFIG_ERROR
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state IDLE; every output 0; all internal counters and flags 0.
- All outputs are registered.
- States: IDLE, CHECK, MEASURE, LATCH, REPORT.
- IDLE: when start=1 and abort=0, latch the four cfg_* inputs into the conv_* outputs, then go to CHECK. A start that arrives in any other state is ignored.
- CHECK (1 cycle):
  - Config error if cfg_min_thr > cfg_max_thr, cfg_max_checks = 0 or cfg_max_rate = 0. On error go to REPORT with status 11 and all res_* = 0.
  - Otherwise go to MEASURE.
  - Timing: start seen at cycle N, CHECK at N+1, conv_measuring=1 from N+2.
- MEASURE:
  - conv_measuring=1 for the whole state and drops on exit.
  - On entry: conv_adc = 0, first_seen = 0, sample counter = 0, timeout counter = 0, and adc_req=1 in the first MEASURE cycle.
  - adc_req stays high until a cycle with adc_ack=1. In that cycle capture conv_adc <= adc_data, set first_seen=1 and clear the sample counter. adc_req=0 from the next cycle.
  - The sample counter increments while adc_req=0. The next adc_req is raised when the counter reaches SAMPLE_DIV-1.
  - Only one request is ever outstanding. adc_ack while adc_req=0 is ignored.
  - conv_done is ignored while first_seen=0, because the converter flags done on a zero ADC input.
  - Timeout counter increments every MEASURE cycle and saturates.
  - Exit priority, evaluated each cycle: abort, then conv_done (with first_seen=1), then timeout counter = TIMEOUT_CYCLES-1.
    - abort: go to REPORT, status 10, res_* = 0.
    - conv_done: go to LATCH.
    - timeout: go to REPORT, status 01, res_* = current conv_* results.
- LATCH (1 cycle): conv_measuring is still 1 so converter values are preserved. Capture conv_* results into res_*, status 00, go to REPORT. abort here still wins and gives status 10 with zero results.
- REPORT:
  - conv_measuring=0, adc_req=0, res_valid=1.
  - res_* and res_status are held stable while res_valid=1 and res_ready=0.
  - Handshake completes in a cycle with res_valid & res_ready; the next cycle is IDLE with res_valid=0. res_* keep their last values until the next capture.
  - abort and start are ignored in REPORT.
- Reset asserted in any state forces the reset values in the following cycle, including mid-handshake. An in-flight ADC request is dropped.
- Counter widths:
  - Sample counter: clog2(SAMPLE_DIV) bits.
  - Timeout counter: 16 bits.
  - No arithmetic is performed on result data; values pass through unmodified.

Test Plan:
- cfg_min=120, cfg_max=60, start: busy=1, 2 cycles later res_valid=1, res_status=11, res_*=0, conv_measuring never asserted.
- Valid config (50/100/10/200), SAMPLE_DIV=4, ADC acks after 2 cycles with data 512; converter model raises done with count=10, avg=100: res_avg=100, res_count=10, status 00. Check adc_req spacing is exactly 4 cycles from capture to next request.
- conv_done=1 forced before the first adc_ack: ignored, stays in MEASURE. After the first ack, done moves to LATCH then REPORT.
- TIMEOUT_CYCLES=20, adc_ack never asserted: REPORT in the cycle after the 20th MEASURE cycle, status 01, adc_req drops.
- abort in the same cycle as conv_done: status 10, res_*=0. Then hold res_ready=0 for 5 cycles: outputs stable. Pulse res_ready: IDLE next cycle. A start issued during REPORT is ignored.
- reset pulsed mid-MEASURE with adc_req=1: next cycle all outputs 0 and state IDLE. A new start runs a normal session.
